// File: rtl/des_pkg.sv
// Shared DES tables, permutation helpers and FSM state type.
package des_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int IP_T [64] = '{
        58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
        62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
        57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
        61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};

    localparam int FP_T [64] = '{
        40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
        38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
        36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
        34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};

    localparam int E_T [48] = '{
        32,1,2,3,4,5,     4,5,6,7,8,9,       8,9,10,11,12,13,    12,13,14,15,16,17,
        16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};

    localparam int P_T [32] = '{
        16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
        2,8,24,14,32,27,3,9,    19,13,30,6,22,11,4,25};

    localparam int PC1_T [56] = '{
        57,49,41,33,25,17,9,1,  58,50,42,34,26,18,10,2,
        59,51,43,35,27,19,11,3, 60,52,44,36,
        63,55,47,39,31,23,15,7, 62,54,46,38,30,22,14,6,
        61,53,45,37,29,21,13,5, 28,20,12,4};

    localparam int PC2_T [48] = '{
        14,17,11,24,1,5,   3,28,15,6,21,10,   23,19,12,4,26,8,   16,7,27,20,13,2,
        41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};

    // Right-rotation amount before round n (index n-1); K16 comes straight from PC1.
    localparam int SHIFT_DEC [16] = '{0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

    // S-boxes flattened as row*16 + column.
    localparam int SBOX [8][64] = '{
        '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,    0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
          4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,    15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
        '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,    3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
          0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,    13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
        '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,    13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
          13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,    1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
        '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,    13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
          10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,    3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
        '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,    14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
          4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,    11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
        '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,    10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
          9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,    4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
        '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,    13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
          1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,    6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
        '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,    1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
          7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,    2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

    // Output bit i takes input bit TABLE[i-1]; bit 1 is the MSB throughout.
    function automatic logic [1:64] ip_perm(input logic [1:64] x);
        logic [1:64] y;
        for (int i = 0; i < 64; i++) y[i+1] = x[IP_T[i]];
        return y;
    endfunction

    function automatic logic [1:64] fp_perm(input logic [1:64] x);
        logic [1:64] y;
        for (int i = 0; i < 64; i++) y[i+1] = x[FP_T[i]];
        return y;
    endfunction

    function automatic logic [1:48] e_expand(input logic [1:32] x);
        logic [1:48] y;
        for (int i = 0; i < 48; i++) y[i+1] = x[E_T[i]];
        return y;
    endfunction

    function automatic logic [1:32] p_perm(input logic [1:32] x);
        logic [1:32] y;
        for (int i = 0; i < 32; i++) y[i+1] = x[P_T[i]];
        return y;
    endfunction

    function automatic logic [1:56] pc1_perm(input logic [1:64] x);
        logic [1:56] y;
        for (int i = 0; i < 56; i++) y[i+1] = x[PC1_T[i]];
        return y;
    endfunction

    function automatic logic [1:48] pc2_perm(input logic [1:56] x);
        logic [1:48] y;
        for (int i = 0; i < 48; i++) y[i+1] = x[PC2_T[i]];
        return y;
    endfunction

    // Eight 6-to-4 lookups; row from the outer bits, column from the inner four.
    function automatic logic [1:32] sbox_sub(input logic [1:48] x);
        logic [1:32] y;
        logic [5:0]  b;
        int          idx;
        for (int j = 0; j < 8; j++) begin
            b   = x[6*j+1 +: 6];
            idx = int'({b[5], b[0]}) * 16 + int'(b[4:1]);
            y[4*j+1 +: 4] = 4'(SBOX[j][idx]);
        end
        return y;
    endfunction

endpackage

// File: rtl/des_dec_round.sv
// One combinational DES decryption round: reverse key-schedule step plus Feistel update.
module des_dec_round
    import des_pkg::*;
(
    input  logic [1:32] l,
    input  logic [1:32] r,
    input  logic [1:28] c,
    input  logic [1:28] d,
    input  logic [1:0]  shift,
    output logic [1:32] l_next,
    output logic [1:32] r_next,
    output logic [1:28] c_next,
    output logic [1:28] d_next
);

    logic [1:48] subkey;

    // Walk the key schedule backwards: rotate C and D right by 0, 1 or 2.
    always_comb begin
        c_next = c;
        d_next = d;
        case (shift)
            2'd1: begin
                c_next = {c[28], c[1:27]};
                d_next = {d[28], d[1:27]};
            end
            2'd2: begin
                c_next = {c[27:28], c[1:26]};
                d_next = {d[27:28], d[1:26]};
            end
            default: ;
        endcase
    end

    assign subkey = pc2_perm({c_next, d_next});
    assign l_next = r;
    assign r_next = l ^ p_perm(sbox_sub(e_expand(r) ^ subkey));

endmodule

// File: rtl/des_decrypt_iter.sv
// Iterative DES decryption core with valid/ready handshakes on both sides.
module des_decrypt_iter
    import des_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:64] in_data,
    input  logic [1:64] in_key,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:64] out_data
);

    if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2 && ROUNDS_PER_CYCLE != 4 &&
        ROUNDS_PER_CYCLE != 8 && ROUNDS_PER_CYCLE != 16) begin : g_bad_rpc
        $error("ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    localparam int         R    = ROUNDS_PER_CYCLE;
    localparam logic [4:0] STEP = 5'(ROUNDS_PER_CYCLE);

    state_t      state;
    logic [4:0]  cnt;
    logic [1:32] l_reg, r_reg;
    logic [1:28] c_reg, d_reg;

    logic [1:32] l_ch [0:R];
    logic [1:32] r_ch [0:R];
    logic [1:28] c_ch [0:R];
    logic [1:28] d_ch [0:R];
    logic [1:64] ip_in;
    logic [1:56] pc1_key;

    assign ip_in    = ip_perm(in_data);
    assign pc1_key  = pc1_perm(in_key);
    assign in_ready = (state == IDLE);

    assign l_ch[0] = l_reg;
    assign r_ch[0] = r_reg;
    assign c_ch[0] = c_reg;
    assign d_ch[0] = d_reg;

    // Round chain; round index is the counter plus position in the chain.
    for (genvar k = 0; k < R; k++) begin : g_round
        logic [3:0] idx;
        assign idx = cnt[3:0] + 4'(k);
        des_dec_round u_round (
            .l      (l_ch[k]),
            .r      (r_ch[k]),
            .c      (c_ch[k]),
            .d      (d_ch[k]),
            .shift  (2'(SHIFT_DEC[idx])),
            .l_next (l_ch[k+1]),
            .r_next (r_ch[k+1]),
            .c_next (c_ch[k+1]),
            .d_next (d_ch[k+1])
        );
    end

    // Control FSM and datapath registers: load, iterate, hold result until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            l_reg     <= '0;
            r_reg     <= '0;
            c_reg     <= '0;
            d_reg     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    l_reg <= ip_in[1:32];
                    r_reg <= ip_in[33:64];
                    c_reg <= pc1_key[1:28];
                    d_reg <= pc1_key[29:56];
                    cnt   <= '0;
                    state <= RUN;
                end
                RUN: begin
                    l_reg <= l_ch[R];
                    r_reg <= r_ch[R];
                    c_reg <= c_ch[R];
                    d_reg <= d_ch[R];
                    cnt   <= cnt + STEP;
                    if (cnt + STEP == 5'd16) begin
                        // Final swap folded into the FP operand order.
                        out_data  <= fp_perm({r_ch[R], l_ch[R]});
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_des_decrypt_iter.sv
// Self-checking bench for des_decrypt_iter with an expected-plaintext scoreboard.
module tb_des_decrypt_iter;

    localparam logic [63:0] KEY1 = 64'h133457799BBCDFF1;
    localparam logic [63:0] CT1  = 64'h85E813540F0AB405;
    localparam logic [63:0] PT1  = 64'h0123456789ABCDEF;
    localparam logic [63:0] KEY2 = 64'h0E329232EA6D0D73;
    localparam logic [63:0] CT2  = 64'h0000000000000000;
    localparam logic [63:0] PT2  = 64'h8787878787878787;
    localparam int LIMIT = 200;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
    logic [1:64] in_data = '0, in_key = '0, out_data;

    always #5 clk = ~clk;

    des_decrypt_iter #(.ROUNDS_PER_CYCLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_key(in_key), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data));

    localparam int SW_RPC [3] = '{2, 4, 16};
    logic        sw_in_valid [3];
    logic        sw_in_ready [3];
    logic        sw_out_valid [3];
    logic [1:64] sw_out_data [3];
    logic        sw_out_ready = 1'b1;

    for (genvar g = 0; g < 3; g++) begin : g_sw
        des_decrypt_iter #(.ROUNDS_PER_CYCLE(SW_RPC[g])) u_sw (
            .clk(clk), .rst_n(rst_n), .in_valid(sw_in_valid[g]), .in_ready(sw_in_ready[g]),
            .in_data(in_data), .in_key(in_key), .out_valid(sw_out_valid[g]),
            .out_ready(sw_out_ready), .out_data(sw_out_data[g]));
    end

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] exp_q [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] pop_exp();
        if (exp_q.size() == 0) return 'x;
        return exp_q.pop_front();
    endfunction

    // Present a block, push its expected plaintext, return just after the accept edge.
    task automatic send(input logic [63:0] d, input logic [63:0] k, input logic [63:0] exp);
        int n = 0;
        in_data  = d;
        in_key   = k;
        in_valid = 1'b1;
        while (!in_ready && n < LIMIT) begin tick(); n++; end
        tick();
        in_valid = 1'b0;
        exp_q.push_back(exp);
    endtask

    // Count edges until out_valid, bounded.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < LIMIT) begin tick(); lat++; end
    endtask

    task automatic test_reset();
        logic [63:0] e;
        for (int g = 0; g < 3; g++) sw_in_valid[g] = 1'b0;
        #3;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        e = '0;
        n_tests++; if (out_data !== e) begin n_fail++; $display("FAIL rst_out_data: got %h want %h", out_data, e); end
        in_data = CT1; in_key = KEY1; in_valid = 1'b1;
        tick(); tick();
        n_tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL rst_no_transfer: in_ready %b out_valid %b want 1/0", in_ready, out_valid);
        end
        in_valid = 1'b0;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_vector1();
        int lat;
        logic [63:0] e;
        out_ready = 1'b1;
        send(CT1, KEY1, PT1);
        wait_valid(lat);
        n_tests++; if (lat != 16) begin n_fail++; $display("FAIL v1_latency: got %0d want 16", lat); end
        e = pop_exp();
        n_tests++; if (out_data !== e) begin n_fail++; $display("FAIL v1_data: got %h want %h", out_data, e); end
        tick();
        n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL v1_handshake: out_valid %b in_ready %b want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        bit busy_ok;
        logic [63:0] e;
        out_ready = 1'b1;
        send(CT1, KEY1, PT1);
        wait_valid(lat);
        e = pop_exp();
        n_tests++; if (out_data !== e) begin n_fail++; $display("FAIL b2b_first_data: got %h want %h", out_data, e); end
        // Offer the next block during the DONE handshake cycle.
        in_data = CT2; in_key = KEY2; in_valid = 1'b1;
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_done_ready: got %b want 0", in_ready); end
        tick();
        n_tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL b2b_idle_after_hs: in_ready %b out_valid %b want 1/0", in_ready, out_valid);
        end
        tick();
        in_valid = 1'b0;
        exp_q.push_back(PT2);
        busy_ok = 1'b1;
        lat = 0;
        while (!out_valid && lat < LIMIT) begin
            if (in_ready !== 1'b0) busy_ok = 1'b0;
            tick();
            lat++;
        end
        if (in_ready !== 1'b0) busy_ok = 1'b0;
        n_tests++; if (!busy_ok) begin n_fail++; $display("FAIL b2b_busy_ready: in_ready seen high, want low"); end
        n_tests++; if (lat != 16) begin n_fail++; $display("FAIL b2b_latency: got %0d want 16", lat); end
        e = pop_exp();
        n_tests++; if (out_data !== e) begin n_fail++; $display("FAIL b2b_second_data: got %h want %h", out_data, e); end
        tick();
    endtask

    task automatic test_backpressure();
        int lat;
        bit hold_ok, quiet_ok;
        logic [63:0] held, e;
        out_ready = 1'b0;
        send(CT1, KEY1, PT1);
        wait_valid(lat);
        held = out_data;
        hold_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (out_valid !== 1'b1 || out_data !== held || in_ready !== 1'b0) hold_ok = 1'b0;
            if (i == 3) begin in_data = CT2; in_key = KEY2; in_valid = 1'b1; end
            if (i == 4) in_valid = 1'b0;
            tick();
        end
        n_tests++; if (!hold_ok) begin n_fail++; $display("FAIL bp_hold: output not held, data %h want %h", out_data, held); end
        e = pop_exp();
        n_tests++; if (held !== e) begin n_fail++; $display("FAIL bp_data: got %h want %h", held, e); end
        out_ready = 1'b1;
        tick();
        n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_release: out_valid %b in_ready %b want 0/1", out_valid, in_ready);
        end
        quiet_ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (out_valid !== 1'b0 || in_ready !== 1'b1) quiet_ok = 1'b0;
            tick();
        end
        n_tests++; if (!quiet_ok) begin n_fail++; $display("FAIL bp_ignored_pulse: core started on busy-time in_valid"); end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        logic [63:0] e;
        out_ready = 1'b1;
        in_data = CT1; in_key = KEY1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL midrst_immediate: out_valid %b in_ready %b want 0/1", out_valid, in_ready);
        end
        tick();
        rst_n = 1'b1;
        tick();
        send(CT1, KEY1, PT1);
        wait_valid(lat);
        n_tests++; if (lat != 16) begin n_fail++; $display("FAIL midrst_latency: got %0d want 16", lat); end
        e = pop_exp();
        n_tests++; if (out_data !== e) begin n_fail++; $display("FAIL midrst_data: got %h want %h", out_data, e); end
        tick();
    endtask

    task automatic test_parity();
        int lat;
        logic [63:0] e;
        out_ready = 1'b1;
        send(CT1, KEY1 ^ 64'h0101010101010101, PT1);
        wait_valid(lat);
        e = pop_exp();
        n_tests++; if (out_data !== e) begin n_fail++; $display("FAIL parity_data: got %h want %h", out_data, e); end
        tick();
    endtask

    task automatic test_sweep();
        int lat;
        logic [63:0] e;
        for (int g = 0; g < 3; g++) begin
            in_data = CT1; in_key = KEY1;
            n_tests++; if (sw_in_ready[g] !== 1'b1) begin n_fail++; $display("FAIL sweep%0d_ready: got %b want 1", SW_RPC[g], sw_in_ready[g]); end
            sw_in_valid[g] = 1'b1;
            tick();
            sw_in_valid[g] = 1'b0;
            exp_q.push_back(PT1);
            lat = 0;
            while (!sw_out_valid[g] && lat < LIMIT) begin tick(); lat++; end
            n_tests++; if (lat != 16 / SW_RPC[g]) begin
                n_fail++; $display("FAIL sweep%0d_latency: got %0d want %0d", SW_RPC[g], lat, 16 / SW_RPC[g]);
            end
            e = pop_exp();
            n_tests++; if (sw_out_data[g] !== e) begin
                n_fail++; $display("FAIL sweep%0d_data: got %h want %h", SW_RPC[g], sw_out_data[g], e);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_vector1();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_run();
        test_parity();
        test_sweep();
        n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size()); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/des_decrypt_iter.md
Name: des_decrypt_iter

Overview:
- Iterative DES decryption core: accepts one 64-bit ciphertext block and 64-bit key, runs the 16 Feistel rounds with subkeys in reverse order (K16..K1), and returns the plaintext.
- Inverse-direction companion to the team's per-round encryption datapath; reuses the same expansion, S-box and P-permutation logic for the f-function.
- Sits behind a valid/ready stream on both sides.

Parameters:
- ROUNDS_PER_CYCLE, 1, Feistel rounds evaluated per clock. Legal values: 1, 2, 4, 8, 16. Any other value is an elaboration error.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  ciphertext and key present
- in_ready  output  1  core idle and able to accept
- in_data  input  [1:64]  ciphertext block, DES bit numbering (bit 1 = MSB)
- in_key  input  [1:64]  DES key; parity bits 8,16,...,64 ignored
- out_valid  output  1  plaintext available
- out_ready  input  1  downstream accepts plaintext
- out_data  output  [1:64]  plaintext block

Behaviour:
- Reset values (rst_n low): state IDLE, round counter 0, L/R/C/D registers 0, out_valid 0, out_data 0. Reset is honoured immediately at any point, including mid-RUN; the partial result is discarded.
- in_ready = (state == IDLE); combinational from state. No transfer occurs while rst_n is low.
- States:
  - IDLE: on in_valid & in_ready, register {L0,R0} = IP(in_data) and {C,D} = PC1(in_key); counter cleared; go to RUN. in_data and in_key are sampled only at this edge.
  - RUN: each edge applies ROUNDS_PER_CYCLE rounds and adds ROUNDS_PER_CYCLE to the counter.
  - At the edge completing round 16: out_data = FP({R16,L16}) (final swap, then FP); out_valid = 1; go to DONE.
  - DONE: out_valid and out_data held stable while out_ready is low. On out_valid & out_ready: out_valid = 0, go to IDLE. out_data keeps its last value.
- Round n (n = 1..16):
  - Rotate C and D right by SHIFT_DEC[n]; SHIFT_DEC = 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - Kn' = PC2({C,D}) after the rotation.
  - Update: L' = R; R' = L ^ P(S(E(R) ^ Kn')).
  - Round 1 uses no rotation: PC1 state equals the post-28-shift encryption state, so K16 is produced first.
- Latency: 16/ROUNDS_PER_CYCLE clock edges from the accept edge to out_valid high.
- Throughput: one block per 16/ROUNDS_PER_CYCLE + 2 cycles when out_ready is held high (1 DONE cycle, 1 IDLE cycle).
- in_valid while busy: ignored; no buffering.
- in_valid in the same cycle as the DONE handshake: not accepted, because in_ready is 0. It is accepted on the following cycle.
- Counter width 5 bits; it never wraps, and RUN exits exactly at 16.

Decomposition:
- Shared package des_pkg holds:
  - IP, FP, E, P, PC1, PC2 permutation tables
  - S1..S8 tables
  - SHIFT_DEC array
  - state enum {IDLE, RUN, DONE}
- Sub-module des_dec_round:
  - Combinational single round, inputs L, R, C, D and a shift amount; outputs L', R', C', D'.
  - Instantiated ROUNDS_PER_CYCLE times in a chain.
  - The top level holds only the registers, counter and FSM.

Test Plan:
- Key 133457799BBCDFF1, in_data 85E813540F0AB405, out_ready=1 -> out_data 0123456789ABCDEF; out_valid rises exactly 16 edges after accept.
- Key 0E329232EA6D0D73, in_data 0000000000000000 sent immediately after the previous handshake -> out_data 8787878787878787; in_ready low for the entire RUN and DONE period.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> out_data stable, in_ready=0, a second in_valid pulse is ignored. On out_ready=1 the handshake completes and in_ready returns to 1 the next cycle.
- Assert rst_n low during RUN at round 7 -> out_valid 0 and in_ready 1 immediately. After release, vector 1 completes correctly.
- Sweep ROUNDS_PER_CYCLE = 2, 4, 16 with vector 1 -> same plaintext, latency 8, 4, 1 cycles respectively.
- Key 133457799BBCDFF1 XOR 0101010101010101 (parity bits flipped) with in_data 85E813540F0AB405 -> out_data 0123456789ABCDEF.
